// File: rtl/avalon_mm_cmd_master.sv
// Avalon-MM initiator: turns one command into one read or write transfer,
// with waitrequest handling, fixed read latency and a stall timeout.
module avalon_mm_cmd_master #(
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 0,
   parameter int TIMEOUT      = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_timeout,
   output logic                busy,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   input  logic                avm_waitrequest,
   input  logic [DATA_W-1:0]   avm_readdata
);

   localparam int BE_W = DATA_W / 8;
   localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [2:0]    LAT_LAST = 3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

   typedef enum logic [1:0] {IDLE, XFER, RDWAIT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [2:0]        lat_q, lat_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         read_q        <= 1'b0;
         write_q       <= 1'b0;
         be_q          <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_timeout_q <= 1'b0;
         tmo_q         <= '0;
         lat_q         <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         read_q        <= read_d;
         write_q       <= write_d;
         be_q          <= be_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_timeout_q <= rsp_timeout_d;
         tmo_q         <= tmo_d;
         lat_q         <= lat_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      read_d        = read_q;
      write_d       = write_q;
      be_d          = be_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_timeout_d = rsp_timeout_q;
      tmo_d         = tmo_q;
      lat_d         = lat_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               write_d = cmd_write;
               read_d  = !cmd_write;
               be_d    = '1;
               tmo_d   = '0;
               state_d = XFER;
            end
         end
         XFER: begin
            if (!avm_waitrequest) begin
               read_d  = 1'b0;
               write_d = 1'b0;
               be_d    = '0;
               if (write_q) begin
                  rsp_valid_d   = 1'b1;
                  rsp_rdata_d   = '0;
                  rsp_timeout_d = 1'b0;
                  state_d       = IDLE;
               end else if (READ_LATENCY == 0) begin
                  rsp_valid_d   = 1'b1;
                  rsp_rdata_d   = avm_readdata;
                  rsp_timeout_d = 1'b0;
                  state_d       = IDLE;
               end else begin
                  lat_d   = '0;
                  state_d = RDWAIT;
               end
            // acceptance above takes priority over an expiring counter
            end else if ((TIMEOUT > 0) && (tmo_q == TMO_LAST)) begin
               read_d        = 1'b0;
               write_d       = 1'b0;
               be_d          = '0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_timeout_d = 1'b1;
               state_d       = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         RDWAIT: begin
            if (lat_q == LAT_LAST) begin
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = avm_readdata;
               rsp_timeout_d = 1'b0;
               state_d       = IDLE;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_ready      = (state_q == IDLE);
   assign busy           = (state_q != IDLE);
   assign avm_address    = addr_q;
   assign avm_writedata  = wdata_q;
   assign avm_read       = read_q;
   assign avm_write      = write_q;
   assign avm_byteenable = be_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign rsp_timeout    = rsp_timeout_q;

endmodule
